data_tape_ctrl: RTL and testbench

Initiator-side controller for the data tape memory (1024 x 8 cell array, enable/RW/ADR/word interface). Owns the data pointer and executes the tape-side instructions (> < + - . , and zero-test) by issuing read and read-modify-write cycles to the memory. Sits between the instruction decoder (command handshake) and the tape memory. Also provides a whole-tape clear sequence for program start.

---
 rtl/data_tape_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_data_tape_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_tape_ctrl.sv
// rtl/data_tape_ctrl.sv - data tape controller: pointer ops, cell read-modify-write, OUT/IN/TEST, tape clear
//
// Purpose:
//   Initiator-side controller for the data tape memory. Owns the data pointer and
//   turns each decoder command into zero, one or two memory cycles. A whole-tape
//   clear sweeps every address writing zero.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cmd_valid/ready   command handshake; ready only while idle
//   cmd_op            0 CLEAR, 1 INC_PTR, 2 DEC_PTR, 3 INC_VAL, 4 DEC_VAL, 5 OUT, 6 IN, 7 TEST
//   in_data           byte written by IN, captured at accept
//   out_data          cell value from the last OUT (held)
//   out_valid         one-cycle pulse with OUT completion
//   cell_zero         result of the last TEST (held)
//   done              one-cycle pulse on command completion
//   ptr               current data pointer
//   mem_enable        memory strobe
//   mem_RW            1 read, 0 write; held at 1 while the strobe is low
//   mem_ADR           memory address
//   mem_word_out      write data
//   mem_word_in       read data, valid the cycle after a read strobe
module data_tape_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd_op,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              cell_zero,
  output logic              done,
  output logic [ADDR_W-1:0] ptr,
  output logic              mem_enable,
  output logic              mem_RW,
  output logic [ADDR_W-1:0] mem_ADR,
  output logic [DATA_W-1:0] mem_word_out,
  input  logic [DATA_W-1:0] mem_word_in
);

  localparam logic [2:0] OP_CLEAR   = 3'd0;
  localparam logic [2:0] OP_INC_PTR = 3'd1;
  localparam logic [2:0] OP_DEC_PTR = 3'd2;
  localparam logic [2:0] OP_INC_VAL = 3'd3;
  localparam logic [2:0] OP_DEC_VAL = 3'd4;
  localparam logic [2:0] OP_OUT     = 3'd5;
  localparam logic [2:0] OP_IN      = 3'd6;
  localparam logic [2:0] OP_TEST    = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_WRITE,
    S_CLEAR
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   in_q, in_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   sweep_q, sweep_d;
  logic                done_q, done_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                cell_zero_q, cell_zero_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      op_q        <= OP_CLEAR;
      in_q        <= '0;
      wdata_q     <= '0;
      sweep_q     <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cell_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_q        <= op_d;
      in_q        <= in_d;
      wdata_q     <= wdata_d;
      sweep_q     <= sweep_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cell_zero_q <= cell_zero_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_d        = op_q;
    in_d        = in_q;
    wdata_d     = wdata_q;
    sweep_d     = sweep_q;
    done_d      = 1'b0;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    cell_zero_d = cell_zero_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d = cmd_op;
          in_d = in_data;
          case (cmd_op)
            // Pointer moves never touch memory, so they complete in place and
            // leave the controller ready for a back-to-back command.
            OP_INC_PTR: begin
              ptr_d  = ptr_q + ADDR_W'(1);
              done_d = 1'b1;
            end
            OP_DEC_PTR: begin
              ptr_d  = ptr_q - ADDR_W'(1);
              done_d = 1'b1;
            end
            OP_CLEAR: begin
              state_d = S_CLEAR;
              sweep_d = '0;
            end
            default: state_d = S_READ;
          endcase
        end
      end

      S_READ: state_d = S_CAPT;

      S_CAPT: begin
        case (op_q)
          OP_INC_VAL: begin
            wdata_d = mem_word_in + DATA_W'(1);
            state_d = S_WRITE;
          end
          OP_DEC_VAL: begin
            wdata_d = mem_word_in - DATA_W'(1);
            state_d = S_WRITE;
          end
          // IN still performs the read so every cell-writing command has the
          // same timing; the read value is dropped here.
          OP_IN: begin
            wdata_d = in_q;
            state_d = S_WRITE;
          end
          OP_OUT: begin
            out_data_d  = mem_word_in;
            out_valid_d = 1'b1;
            done_d      = 1'b1;
            state_d     = S_IDLE;
          end
          OP_TEST: begin
            cell_zero_d = (mem_word_in == '0);
            done_d      = 1'b1;
            state_d     = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end

      S_WRITE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      S_CLEAR: begin
        sweep_d = sweep_q + ADDR_W'(1);
        if (sweep_q == '1) begin
          ptr_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Bus signals decode straight from the state register so an asynchronous
  // reset drops the strobe at once and an in-flight write is never issued.
  assign mem_enable   = (state_q == S_READ) || (state_q == S_WRITE) || (state_q == S_CLEAR);
  assign mem_RW       = !((state_q == S_WRITE) || (state_q == S_CLEAR));
  assign mem_ADR      = (state_q == S_CLEAR) ? sweep_q : ptr_q;
  assign mem_word_out = (state_q == S_WRITE) ? wdata_q : '0;

  assign cmd_ready = (state_q == S_IDLE);
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign cell_zero = cell_zero_q;
  assign ptr       = ptr_q;

endmodule

// File: tb/tb_data_tape_ctrl.sv
// tb/tb_data_tape_ctrl.sv - self-checking bench for data_tape_ctrl
module tb_data_tape_ctrl;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  localparam logic [2:0] OP_CLEAR   = 3'd0;
  localparam logic [2:0] OP_INC_PTR = 3'd1;
  localparam logic [2:0] OP_DEC_PTR = 3'd2;
  localparam logic [2:0] OP_INC_VAL = 3'd3;
  localparam logic [2:0] OP_DEC_VAL = 3'd4;
  localparam logic [2:0] OP_OUT     = 3'd5;
  localparam logic [2:0] OP_IN      = 3'd6;
  localparam logic [2:0] OP_TEST    = 3'd7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd_op = 3'd0;
  logic [DW-1:0] in_data = '0;
  logic          cmd_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          cell_zero;
  logic          done;
  logic [AW-1:0] ptr;
  logic          mem_enable;
  logic          mem_RW;
  logic [AW-1:0] mem_ADR;
  logic [DW-1:0] mem_word_out;
  logic [DW-1:0] mem_word_in;

  data_tape_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .in_data(in_data), .out_data(out_data),
    .out_valid(out_valid), .cell_zero(cell_zero), .done(done), .ptr(ptr),
    .mem_enable(mem_enable), .mem_RW(mem_RW), .mem_ADR(mem_ADR),
    .mem_word_out(mem_word_out), .mem_word_in(mem_word_in)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Tape memory: synchronous read, data valid the cycle after the strobe.
  logic [DW-1:0] tape [DEPTH];
  logic [DW-1:0] rd_q = '0;
  always @(posedge clk) begin
    if (mem_enable) begin
      if (mem_RW) rd_q <= tape[mem_ADR];
      else        tape[mem_ADR] = mem_word_out;
    end
  end
  assign mem_word_in = rd_q;

  // Reference model: a command timeline indexed by cycles since accept.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [AW-1:0] m_ptr = '0;
  logic          m_busy = 1'b0, m_done = 1'b0, m_outv = 1'b0, m_zero = 1'b0;
  logic [DW-1:0] m_out = '0, m_cell = '0, m_new = '0;
  logic [2:0]    m_op = 3'd0;
  int            m_k = 0, m_lat = 0;

  function automatic logic is_rmw(input logic [2:0] op);
    return (op == OP_INC_VAL) || (op == OP_DEC_VAL) || (op == OP_IN);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr = '0; m_busy = 1'b0; m_done = 1'b0; m_outv = 1'b0;
      m_zero = 1'b0; m_out = '0; m_k = 0;
    end else begin
      m_done = 1'b0;
      m_outv = 1'b0;
      if (m_busy) begin
        if (m_op == OP_CLEAR && m_k <= DEPTH) ref_mem[m_k-1] = '0;
        else if (is_rmw(m_op) && m_k == 3) ref_mem[m_ptr] = m_new;
        m_k++;
        if (m_k == m_lat) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          if (m_op == OP_OUT) begin m_out = m_cell; m_outv = 1'b1; end
          if (m_op == OP_TEST) m_zero = (m_cell == 0);
          if (m_op == OP_CLEAR) m_ptr = '0;
        end
      end else if (cmd_valid) begin
        case (cmd_op)
          OP_INC_PTR: begin m_ptr = m_ptr + 1'b1; m_done = 1'b1; end
          OP_DEC_PTR: begin m_ptr = m_ptr - 1'b1; m_done = 1'b1; end
          default: begin
            m_busy = 1'b1;
            m_k    = 1;
            m_op   = cmd_op;
            m_cell = ref_mem[m_ptr];
            if (cmd_op == OP_INC_VAL)      m_new = m_cell + 8'd1;
            else if (cmd_op == OP_DEC_VAL) m_new = m_cell - 8'd1;
            else                           m_new = in_data;
            if (cmd_op == OP_CLEAR) m_lat = DEPTH + 1;
            else if (cmd_op == OP_OUT || cmd_op == OP_TEST) m_lat = 3;
            else m_lat = 4;
          end
        endcase
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    logic rd_c, wr_c;
    if (rst_n) begin
      wr_c = m_busy && ((m_op == OP_CLEAR) || (is_rmw(m_op) && m_k == 3));
      rd_c = m_busy && (m_op != OP_CLEAR) && (m_k == 1);
      chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("out_valid", 32'(out_valid), 32'(m_outv));
      chk("out_data", 32'(out_data), 32'(m_out));
      chk("cell_zero", 32'(cell_zero), 32'(m_zero));
      chk("ptr", 32'(ptr), 32'(m_ptr));
      chk("mem_enable", 32'(mem_enable), 32'(rd_c | wr_c));
      chk("mem_RW", 32'(mem_RW), 32'(!wr_c));
      if (rd_c || wr_c)
        chk("mem_ADR", 32'(mem_ADR), (m_op == OP_CLEAR) ? 32'(m_k - 1) : 32'(m_ptr));
      if (wr_c)
        chk("mem_word_out", 32'(mem_word_out), (m_op == OP_CLEAR) ? 32'd0 : 32'(m_new));
      if (done) done_cnt++;
    end
  end

  task automatic send(input logic [2:0] op, input logic [DW-1:0] d);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    in_data   = d;
    @(negedge clk);
    while (!cmd_ready && n < 3000) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("send_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #2;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int lat);
    int n = 0;
    @(negedge clk);
    while (!done && n < 3000) begin @(negedge clk); n++; end
    chk(name, done ? 32'(cyc - acc_cyc + 1) : 32'hffffffff, 32'(lat));
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int bad;
    for (int i = 0; i < DEPTH; i++) begin
      tape[i]    = 8'($urandom_range(1, 255));
      ref_mem[i] = tape[i];
    end
    tape[5]    = 8'hFF;
    ref_mem[5] = 8'hFF;

    @(posedge clk); #2;
    idle(2);
    chk("rst_ptr", 32'(ptr), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_cell_zero", 32'(cell_zero), 32'd0);
    chk("rst_mem_enable", 32'(mem_enable), 32'd0);
    chk("rst_mem_RW", 32'(mem_RW), 32'd1);
    chk("rst_mem_ADR", 32'(mem_ADR), 32'd0);
    chk("rst_mem_word_out", 32'(mem_word_out), 32'd0);
    rst_n = 1'b1;
    idle(1);

    for (int i = 0; i < 3; i++) begin
      send(OP_INC_PTR, 8'h00);
      wait_done("inc_ptr_latency", 1);
    end
    chk("ptr_after_3_inc", 32'(ptr), 32'd3);

    pulse_reset();
    send(OP_DEC_PTR, 8'h00);
    wait_done("dec_ptr_latency", 1);
    chk("ptr_wrap_down", 32'(ptr), 32'd1023);
    send(OP_INC_PTR, 8'h00);
    wait_done("inc_ptr_latency", 1);
    chk("ptr_wrap_up", 32'(ptr), 32'd0);

    for (int i = 0; i < 5; i++) send(OP_INC_PTR, 8'h00);
    idle(1);
    chk("ptr_at_5", 32'(ptr), 32'd5);
    send(OP_INC_VAL, 8'h00);
    wait_done("inc_val_latency", 4);
    chk("cell5_wrap_up", 32'(tape[5]), 32'h00);
    send(OP_TEST, 8'h00);
    wait_done("test_latency", 3);
    chk("cell_zero_after_wrap", 32'(cell_zero), 32'd1);

    send(OP_DEC_VAL, 8'h00);
    wait_done("dec_val_latency", 4);
    send(OP_OUT, 8'h00);
    wait_done("out_latency", 3);
    chk("out_after_dec_wrap", 32'(out_data), 32'hFF);

    bad = done_cnt;
    send(OP_IN, 8'h41);
    send(OP_OUT, 8'h00);
    wait_done("out_after_in_latency", 3);
    chk("out_after_in", 32'(out_data), 32'h41);
    idle(4);
    chk("done_pulses_in_out", 32'(done_cnt - bad), 32'd2);

    send(OP_INC_PTR, 8'h00);
    send(OP_INC_PTR, 8'h00);
    idle(1);
    chk("ptr_at_7", 32'(ptr), 32'd7);
    send(OP_CLEAR, 8'h00);
    wait_done("clear_latency", 1025);
    chk("ptr_after_clear", 32'(ptr), 32'd0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (tape[i] != 0) bad++;
    chk("nonzero_cells_after_clear", 32'(bad), 32'd0);

    send(OP_IN, 8'h33);
    wait_done("in_latency", 4);
    send(OP_CLEAR, 8'h00);
    idle(100);
    rst_n = 1'b0;
    #1;
    chk("midsweep_mem_enable", 32'(mem_enable), 32'd0);
    chk("midsweep_cmd_ready", 32'(cmd_ready), 32'd1);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    send(OP_IN, 8'h77);
    wait_done("in_latency", 4);
    send(OP_INC_VAL, 8'h00);
    idle(2);
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    chk("write_dropped_on_reset", 32'(tape[0]), 32'h77);

    for (int i = 0; i < 300; i++) begin
      send(3'($urandom_range(1, 7)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 4));
    end
    idle(8);

    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (tape[i] !== ref_mem[i]) bad++;
    chk("tape_vs_model", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
